// File: rtl/calc_cmd_sequencer_if.sv
// calc_cmd_sequencer_if: key-event channel, command-word channel and result
// reporting for the calculator command sequencer.
// The master modport is the sequencer's view: it receives key events and
// initiates command words.
// The slave modport is the environment's view: the keypad scanner plus the
// calculator.
interface calc_cmd_sequencer_if;
    logic        key_valid;
    logic [1:0]  key_kind;
    logic [3:0]  key_data;
    logic        key_ready;
    logic [13:0] cmd_word;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  res_in;
    logic [3:0]  result;
    logic        result_valid;
    logic        err;

    modport master (
        input  key_valid, key_kind, key_data, cmd_ready, res_in,
        output key_ready, cmd_word, cmd_valid, result, result_valid, err
    );

    modport slave (
        output key_valid, key_kind, key_data, cmd_ready, res_in,
        input  key_ready, cmd_word, cmd_valid, result, result_valid, err
    );
endinterface

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: assembles digit/operator/enter/clear key events into the
// packed command word {op, a, b, 4'b0000}.
// It hands the word to the calculator over valid/ready, then captures and
// reports the returned result.
// Optional feature macro: CALC_CHAIN_EN. When it is defined, an operator key
// typed straight after a result reuses that result as operand A.
module calc_cmd_sequencer (
    input  logic                   clk,
    input  logic                   rst,
    calc_cmd_sequencer_if.master   bus
);

    localparam logic [1:0] KIND_DIGIT = 2'b00;
    localparam logic [1:0] KIND_OPER  = 2'b01;
    localparam logic [1:0] KIND_ENTER = 2'b10;
    localparam logic [1:0] KIND_CLEAR = 2'b11;
    localparam logic [1:0] OP_NEG     = 2'b11;

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_OP = 3'd1,
        ENTER_B  = 3'd2,
        ARMED    = 3'd3,
        ISSUE    = 3'd4,
        CAPTURE  = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [1:0] op_q, op_d;
    logic       chain_ok_q, chain_ok_d;
    logic [3:0] result_q, result_d;
    logic       result_valid_q, result_valid_d;
    logic       err_q, err_d;
    logic       key_ready;
    logic       key_accept;

    // Keys are only taken while the operands are being entered.
    assign key_ready  = (state_q != ISSUE) && (state_q != CAPTURE);
    assign key_accept = bus.key_valid && key_ready;

    // Next-state and register-update logic for the key sequencing FSM.
    always_comb begin
        state_d        = state_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        chain_ok_d     = chain_ok_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        err_d          = 1'b0;

        if (key_accept && bus.key_kind == KIND_CLEAR) begin
            state_d    = ENTER_A;
            a_d        = 4'd0;
            b_d        = 4'd0;
            op_d       = 2'd0;
            chain_ok_d = 1'b0;
        end else begin
            case (state_q)
                ENTER_A: begin
                    if (key_accept) begin
                        case (bus.key_kind)
                            KIND_DIGIT: begin
                                a_d     = bus.key_data;
                                state_d = ENTER_OP;
                            end
                            KIND_OPER: begin
`ifdef CALC_CHAIN_EN
                                if (chain_ok_q) begin
                                    a_d  = result_q;
                                    op_d = bus.key_data[1:0];
                                    if (bus.key_data[1:0] == OP_NEG) begin
                                        b_d     = 4'd0;
                                        state_d = ISSUE;
                                    end else begin
                                        state_d = ENTER_B;
                                    end
                                end else begin
                                    err_d = 1'b1;
                                end
`else
                                err_d = 1'b1;
`endif
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                ENTER_OP: begin
                    if (key_accept) begin
                        case (bus.key_kind)
                            KIND_DIGIT: a_d = bus.key_data;
                            KIND_OPER: begin
                                op_d = bus.key_data[1:0];
                                if (bus.key_data[1:0] == OP_NEG) begin
                                    b_d     = 4'd0;
                                    state_d = ISSUE;
                                end else begin
                                    state_d = ENTER_B;
                                end
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                ENTER_B: begin
                    if (key_accept) begin
                        case (bus.key_kind)
                            KIND_DIGIT: begin
                                b_d     = bus.key_data;
                                state_d = ARMED;
                            end
                            KIND_OPER: op_d  = bus.key_data[1:0];
                            default:   err_d = 1'b1;
                        endcase
                    end
                end
                ARMED: begin
                    if (key_accept) begin
                        case (bus.key_kind)
                            KIND_DIGIT: b_d     = bus.key_data;
                            KIND_ENTER: state_d = ISSUE;
                            default:    err_d   = 1'b1;
                        endcase
                    end
                end
                ISSUE: begin
                    if (bus.cmd_ready) begin
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    result_d       = bus.res_in;
                    result_valid_d = 1'b1;
                    chain_ok_d     = 1'b1;
                    state_d        = ENTER_A;
                end
                default: state_d = ENTER_A;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ENTER_A;
            a_q            <= 4'd0;
            b_q            <= 4'd0;
            op_q           <= 2'd0;
            chain_ok_q     <= 1'b0;
            result_q       <= 4'd0;
            result_valid_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            chain_ok_q     <= chain_ok_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            err_q          <= err_d;
        end
    end

    assign bus.key_ready    = key_ready;
    assign bus.cmd_valid    = (state_q == ISSUE);
    assign bus.cmd_word     = {op_q, a_q, b_q, 4'b0000};
    assign bus.result       = result_q;
    assign bus.result_valid = result_valid_q;
    assign bus.err          = err_q;

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb_calc_cmd_sequencer: directed key sequences for calc_cmd_sequencer.
// Each expected command word, result and err pulse is queued when the keys are
// issued. A negedge monitor consumes these expectations whenever the DUT
// presents them.
// The chain scenario follows CALC_CHAIN_EN.
module tb_calc_cmd_sequencer;

    localparam logic [1:0] KIND_DIGIT = 2'b00;
    localparam logic [1:0] KIND_OPER  = 2'b01;
    localparam logic [1:0] KIND_ENTER = 2'b10;
    localparam logic [1:0] KIND_CLEAR = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [13:0] exp_cmd[$];
    logic [3:0]  exp_res[$];
    int          exp_err = 0;

    calc_cmd_sequencer_if bus ();

    calc_cmd_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [13:0] actual,
                               input logic [13:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Present one key and hold it until the DUT takes it, then return just
    // after the accepting clock edge.
    task automatic applyStimulus(input logic [1:0] kind, input logic [3:0] data);
        bit accepted = 1'b0;
        bus.key_valid = 1'b1;
        bus.key_kind  = kind;
        bus.key_data  = data;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (bus.key_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.key_valid = 1'b0;
        if (!accepted) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL key_accept_timeout: kind %0d data %0d never accepted", kind, data);
        end
    endtask

    // Scoreboard monitor: command words, results and err pulses against queues.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL sb_unexpected_cmd: got %h expected no command", bus.cmd_word);
                end else begin
                    checkOutput("sb_cmd_word", bus.cmd_word, exp_cmd[0]);
                    if (bus.cmd_ready) void'(exp_cmd.pop_front());
                end
            end
            if (bus.result_valid) begin
                if (exp_res.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL sb_unexpected_result: got %h expected no result", bus.result);
                end else begin
                    checkOutput("sb_result", {10'd0, bus.result}, {10'd0, exp_res.pop_front()});
                end
            end
            if (bus.err) begin
                tests_run++;
                if (exp_err > 0) begin
                    exp_err--;
                end else begin
                    tests_failed++;
                    $display("[TB] FAIL sb_unexpected_err: got 1 expected 0");
                end
            end
        end
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios.
    initial begin
        bus.key_valid = 1'b0;
        bus.key_kind  = 2'b00;
        bus.key_data  = 4'd0;
        bus.cmd_ready = 1'b0;
        bus.res_in    = 4'd0;

        tick(2);
        checkOutput("rst_cmd_valid", {13'd0, bus.cmd_valid}, 14'd0);
        checkOutput("rst_cmd_word", bus.cmd_word, 14'd0);
        checkOutput("rst_result", {10'd0, bus.result}, 14'd0);
        checkOutput("rst_result_valid", {13'd0, bus.result_valid}, 14'd0);
        checkOutput("rst_err", {13'd0, bus.err}, 14'd0);
        rst = 1'b0;
        checkOutput("rst_key_ready", {13'd0, bus.key_ready}, 14'd1);

        // 3 + 5 = 8, calculator always ready.
        bus.res_in = 4'd8;
        bus.cmd_ready = 1'b1;
        exp_cmd.push_back(14'h0350);
        exp_res.push_back(4'd8);
        applyStimulus(KIND_DIGIT, 4'd3);
        applyStimulus(KIND_OPER, 4'd0);
        applyStimulus(KIND_DIGIT, 4'd5);
        applyStimulus(KIND_ENTER, 4'd0);
        checkOutput("add_cmd_valid", {13'd0, bus.cmd_valid}, 14'd1);
        checkOutput("add_cmd_word", bus.cmd_word, 14'h0350);
        checkOutput("add_key_ready_busy", {13'd0, bus.key_ready}, 14'd0);
        tick(2);
        checkOutput("add_result_valid", {13'd0, bus.result_valid}, 14'd1);
        checkOutput("add_result", {10'd0, bus.result}, 14'd8);
        checkOutput("add_key_ready_back", {13'd0, bus.key_ready}, 14'd1);
        tick(1);
        checkOutput("add_result_valid_pulse", {13'd0, bus.result_valid}, 14'd0);

        // 2 - 7 held off by the calculator for five cycles; a digit waits meanwhile.
        bus.cmd_ready = 1'b0;
        bus.res_in = 4'hB;
        exp_cmd.push_back(14'h1270);
        exp_res.push_back(4'hB);
        applyStimulus(KIND_DIGIT, 4'd2);
        applyStimulus(KIND_OPER, 4'd1);
        applyStimulus(KIND_DIGIT, 4'd7);
        applyStimulus(KIND_ENTER, 4'd0);
        bus.key_valid = 1'b1;
        bus.key_kind  = KIND_DIGIT;
        bus.key_data  = 4'd5;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_cmd_valid", {13'd0, bus.cmd_valid}, 14'd1);
            checkOutput("bp_cmd_word", bus.cmd_word, 14'h1270);
            checkOutput("bp_key_ready", {13'd0, bus.key_ready}, 14'd0);
            tick(1);
        end
        bus.key_valid = 1'b0;
        bus.cmd_ready = 1'b1;
        tick(2);
        checkOutput("bp_result", {10'd0, bus.result}, 14'h000B);
        checkOutput("bp_digit_not_consumed", bus.cmd_word, 14'h1270);

        // Negate A issues straight from the operator key.
        bus.cmd_ready = 1'b0;
        bus.res_in = 4'hC;
        exp_cmd.push_back(14'h3400);
        exp_res.push_back(4'hC);
        applyStimulus(KIND_DIGIT, 4'd4);
        applyStimulus(KIND_OPER, 4'd3);
        checkOutput("neg_cmd_valid", {13'd0, bus.cmd_valid}, 14'd1);
        checkOutput("neg_cmd_word", bus.cmd_word, 14'h3400);
        bus.cmd_ready = 1'b1;
        tick(2);
        checkOutput("neg_result", {10'd0, bus.result}, 14'h000C);

        // Operator overwrite in ENTER_B, digit overwrite and illegal operator in ARMED.
        bus.res_in = 4'd7;
        exp_cmd.push_back(14'h2350);
        exp_res.push_back(4'd7);
        applyStimulus(KIND_DIGIT, 4'd3);
        applyStimulus(KIND_OPER, 4'd1);
        applyStimulus(KIND_OPER, 4'd2);
        applyStimulus(KIND_DIGIT, 4'd4);
        applyStimulus(KIND_DIGIT, 4'd5);
        exp_err++;
        applyStimulus(KIND_OPER, 4'd0);
        checkOutput("armed_op_err", {13'd0, bus.err}, 14'd1);
        applyStimulus(KIND_ENTER, 4'd0);
        tick(2);
        checkOutput("ovr_result", {10'd0, bus.result}, 14'd7);

        // Enter in ENTER_A is illegal; clear from ARMED is silent.
        exp_err++;
        applyStimulus(KIND_ENTER, 4'd0);
        checkOutput("enter_a_err", {13'd0, bus.err}, 14'd1);
        tick(1);
        checkOutput("enter_a_err_pulse", {13'd0, bus.err}, 14'd0);
        applyStimulus(KIND_DIGIT, 4'd9);
        applyStimulus(KIND_OPER, 4'd2);
        applyStimulus(KIND_DIGIT, 4'd1);
        applyStimulus(KIND_CLEAR, 4'd0);
        checkOutput("clr_cmd_valid", {13'd0, bus.cmd_valid}, 14'd0);
        checkOutput("clr_cmd_word", bus.cmd_word, 14'd0);
        checkOutput("clr_err", {13'd0, bus.err}, 14'd0);
        checkOutput("clr_key_ready", {13'd0, bus.key_ready}, 14'd1);

        // Reset while a command is waiting on the calculator.
        bus.cmd_ready = 1'b0;
        exp_cmd.push_back(14'h0110);
        applyStimulus(KIND_DIGIT, 4'd1);
        applyStimulus(KIND_OPER, 4'd0);
        applyStimulus(KIND_DIGIT, 4'd1);
        applyStimulus(KIND_ENTER, 4'd0);
        checkOutput("rsti_cmd_valid_before", {13'd0, bus.cmd_valid}, 14'd1);
        rst = 1'b1;
        tick(1);
        exp_cmd.delete();
        checkOutput("rsti_cmd_valid", {13'd0, bus.cmd_valid}, 14'd0);
        checkOutput("rsti_cmd_word", bus.cmd_word, 14'd0);
        checkOutput("rsti_result", {10'd0, bus.result}, 14'd0);
        checkOutput("rsti_key_ready", {13'd0, bus.key_ready}, 14'd1);
        rst = 1'b0;
        bus.cmd_ready = 1'b1;

        // Produce a result of 6, then try to chain from it.
        bus.res_in = 4'd6;
        exp_cmd.push_back(14'h0150);
        exp_res.push_back(4'd6);
        applyStimulus(KIND_DIGIT, 4'd1);
        applyStimulus(KIND_OPER, 4'd0);
        applyStimulus(KIND_DIGIT, 4'd5);
        applyStimulus(KIND_ENTER, 4'd0);
        tick(2);
        checkOutput("chain_seed_result", {10'd0, bus.result}, 14'd6);
`ifdef CALC_CHAIN_EN
        bus.res_in = 4'd8;
        exp_cmd.push_back(14'h0620);
        exp_res.push_back(4'd8);
        applyStimulus(KIND_OPER, 4'd0);
        applyStimulus(KIND_DIGIT, 4'd2);
        applyStimulus(KIND_ENTER, 4'd0);
        checkOutput("chain_cmd_valid", {13'd0, bus.cmd_valid}, 14'd1);
        checkOutput("chain_cmd_word", bus.cmd_word, 14'h0620);
        tick(2);
        checkOutput("chain_result", {10'd0, bus.result}, 14'd8);
`else
        exp_err++;
        applyStimulus(KIND_OPER, 4'd0);
        checkOutput("nochain_op_err", {13'd0, bus.err}, 14'd1);
        applyStimulus(KIND_DIGIT, 4'd2);
        checkOutput("nochain_digit_loads_a", bus.cmd_word, 14'h0250);
        checkOutput("nochain_cmd_valid", {13'd0, bus.cmd_valid}, 14'd0);
        exp_err++;
        applyStimulus(KIND_ENTER, 4'd0);
        checkOutput("nochain_enter_err", {13'd0, bus.err}, 14'd1);
        applyStimulus(KIND_CLEAR, 4'd0);
`endif

        tick(3);
        checkOutput("end_cmd_queue_empty", 14'(exp_cmd.size()), 14'd0);
        checkOutput("end_res_queue_empty", 14'(exp_res.size()), 14'd0);
        checkOutput("end_err_all_seen", 14'(exp_err), 14'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/calc_cmd_sequencer.md
# calc_cmd_sequencer

Sequential command front end for the 4-bit calculator datapath. It accepts key events (digit, operator, enter, clear) over a valid/ready handshake and assembles them into the packed 14-bit command word `{op[1:0], a[3:0], b[3:0], 4'b0000}`. It presents that word to the calculator with a valid/ready handshake, samples the returned 4-bit result, and reports it. It sits between the keypad scanner and the combinational calculator, as the initiator of the command-word interface.

## Interface
- No parameters. All widths are fixed by the calculator command format.
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: synchronous reset, active-high.
- `key_valid` in 1: a key event is present.
- `key_kind` in 2: key class. 00 digit, 01 operator, 10 enter, 11 clear.
- `key_data` in 4: digit value (0–15) for a digit key; for an operator key, `[1:0]` is the opcode (00 add, 01 sub, 10 or, 11 negate A).
- `key_ready` out 1: the block can accept a key; combinational from state.
- `cmd_word` out 14: command word; the low nibble is always 0.
- `cmd_valid` out 1: `cmd_word` is valid.
- `cmd_ready` in 1: the calculator accepts the command.
- `res_in` in 4: calculator result for the command currently driven.
- `result` out 4: last captured result.
- `result_valid` out 1: one-cycle pulse when `result` is updated.
- `err` out 1: one-cycle pulse when an accepted key is illegal in the current state.

## Operation
- A key is accepted on a cycle where `key_valid && key_ready`. `key_ready` is 1 in the entry states ENTER_A, ENTER_OP, ENTER_B and ARMED, and 0 in ISSUE and CAPTURE.
- A clear key in any entry state:
  - goes to ENTER_A;
  - zeroes a, b and op;
  - clears chain_ok;
  - does not pulse `err`.
- ENTER_A:
  - digit: a ← key_data, go to ENTER_OP.
  - operator: handled as in Configuration.
  - enter: pulse `err`, stay.
- ENTER_OP:
  - digit: a ← key_data, stay (overwrite).
  - operator: op ← key_data[1:0]. If op = 11, b ← 0 and go to ISSUE; otherwise go to ENTER_B.
  - enter: pulse `err`, stay.
- ENTER_B:
  - digit: b ← key_data, go to ARMED.
  - operator: op ← new opcode, stay.
  - enter: pulse `err`, stay.
- ARMED:
  - digit: b ← key_data, stay.
  - enter: go to ISSUE.
  - operator: pulse `err`, stay.
- ISSUE: `cmd_valid` = 1 and `cmd_word` = {op, a, b, 0000}, held stable until handshake. On `cmd_ready`, go to CAPTURE.
- CAPTURE:
  - `cmd_word` is still driven and `cmd_valid` = 0;
  - result ← res_in and chain_ok ← 1;
  - go to ENTER_A.
- `result_valid` is registered. It pulses in the cycle after CAPTURE.
- Arithmetic is done entirely by the calculator. This block performs no width extension or checking.

## Timing
- Reset values:
  - state ENTER_A;
  - `cmd_word` 0, `cmd_valid` 0;
  - `result` 0, `result_valid` 0;
  - `err` 0;
  - a, b, op and chain_ok all 0.
- `key_ready` reads 1 once `rst` is released.
- Enter accepted in ARMED at cycle N: `cmd_valid` = 1 at N+1.
- Handshake (`cmd_valid && cmd_ready`) at cycle M:
  - CAPTURE at M+1, which samples `res_in`;
  - `result_valid` = 1 and `result` updated at M+2;
  - `key_ready` = 1 again at M+2.
- `cmd_ready` held low: `cmd_valid` and `cmd_word` hold indefinitely. No timeout.
- `err` is high in the cycle after the offending key is accepted.
- `rst` asserted in any state, including ISSUE with `cmd_valid` high: next cycle all outputs are at reset values and `cmd_valid` drops with no handshake.
- `key_valid` while `key_ready` = 0: the key is not consumed. The keypad must hold it.

## Configuration
- Macro: `CALC_CHAIN_EN`.
- Defined:
  - An operator key in ENTER_A with chain_ok = 1 loads a ← result and op ← opcode.
  - It then goes to ISSUE if the opcode is 11 (with b ← 0), else to ENTER_B.
  - With chain_ok = 0, it pulses `err`.
- Undefined: an operator key in ENTER_A always pulses `err` and stays in ENTER_A. chain_ok is unused.

## Test plan
- Add: keys 3, add, 5, enter, with `cmd_ready` = 1 and `res_in` = 8 → `cmd_word` = 14'h0350 one cycle after enter. `result` = 8 with a `result_valid` pulse two cycles after the handshake.
- Backpressure: keys 2, sub, 7, enter with `cmd_ready` = 0 for 5 cycles → `cmd_word` holds 14'h1270 and `cmd_valid` stays high for all 5 cycles, `key_ready` = 0. A digit presented meanwhile is not consumed.
- Negate: keys 4, op 11 → `cmd_valid` with `cmd_word` = 14'h3400 on the next cycle, with no B entry or enter needed.
- Errors and clear: enter in ENTER_A → one `err` pulse. Keys 9, or, 1, then clear → state ENTER_A, no `cmd_valid`, no `err`.
- Reset during ISSUE: `rst` high with `cmd_valid` = 1 → next cycle `cmd_valid` = 0, `cmd_word` = 0, `result` = 0.
- Chain: after a result of 6, send keys add, 2, enter.
  - With `CALC_CHAIN_EN`: `cmd_word` = 14'h0620.
  - Without it: an `err` pulse on the add key, and the following digit 2 loads a.
